// File: rtl/output_part.sv
// Purpose: serialises four captured 4-bit words onto a one-hot select / data / load-strobe triple.
// Latency: first word appears one cycle after start is sampled; each word takes 1+STROBE_CYCLES+HOLD_CYCLES cycles.
// Backpressure: none; start is honoured only when idle (incl. the done cycle), otherwise ignored and not queued.
module output_part #(
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] srt_num0,
  input  logic [3:0] srt_num1,
  input  logic [3:0] srt_num2,
  input  logic [3:0] srt_num3,
  output logic [3:0] partA,
  output logic [3:0] partB,
  output logic       partC,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Terminal counts for the per-phase cycle counter. The hold terminal count
  // is unused when the hold phase is skipped.
  localparam logic [3:0] STB_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam bit         NO_HOLD  = (HOLD_CYCLES == 0);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [1:0] idx;
  logic [1:0] idx_nxt;
  logic [3:0] cap [4];

  logic       accept;
  logic       last_word;
  logic       frame_end;

  logic [3:0] partA_nxt;
  logic [3:0] partB_nxt;
  logic       partC_nxt;
  logic       busy_nxt;
  logic       done_nxt;

  assign accept    = (state == IDLE) && start;
  assign last_word = (idx == 2'd3);

  // State register; outputs are registered alongside it from their next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx   <= 2'd0;
      partA <= 4'd0;
      partB <= 4'd0;
      partC <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      partA <= partA_nxt;
      partB <= partB_nxt;
      partC <= partC_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Snapshot of the input words taken when a frame is accepted, so later input
  // changes cannot disturb the frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cap[i] <= 4'd0;
      end
    end else if (accept) begin
      cap[0] <= srt_num0;
      cap[1] <= srt_num1;
      cap[2] <= srt_num2;
      cap[3] <= srt_num3;
    end
  end

  // Next-state: phase sequencing, cycle counting and word index advance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          idx_nxt   = 2'd0;
          cnt_nxt   = 4'd0;
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = 4'd0;
      end
      STROBE: begin
        if (cnt == STB_LAST) begin
          cnt_nxt = 4'd0;
          if (!NO_HOLD) begin
            state_nxt = HOLD;
          end else if (last_word) begin
            state_nxt = IDLE;
            frame_end = 1'b1;
          end else begin
            state_nxt = SETUP;
            idx_nxt   = idx + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HOLD: begin
        if (cnt == HLD_LAST) begin
          cnt_nxt = 4'd0;
          if (last_word) begin
            state_nxt = IDLE;
            frame_end = 1'b1;
          end else begin
            state_nxt = SETUP;
            idx_nxt   = idx + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output next values: select/data only move on SETUP entry, strobe follows
  // STROBE, and done flags the transition that completes word 3.
  always_comb begin
    partA_nxt = partA;
    partB_nxt = partB;
    partC_nxt = (state_nxt == STROBE);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = frame_end;
    if (state_nxt == IDLE) begin
      partA_nxt = 4'd0;
      partB_nxt = 4'd0;
    end else if (state_nxt == SETUP) begin
      partA_nxt = 4'b0001 << idx_nxt;
      // On the accepting edge the snapshot is not loaded yet, so word 0 comes
      // straight from the input.
      partB_nxt = (state == IDLE) ? srt_num0 : cap[idx_nxt];
    end
  end

endmodule

// File: tb/tb_output_part.sv
// Purpose: randomized scoreboard bench for output_part with a default and a minimal-timing instance.
// Latency: expected outputs come from a frame-position model advanced on each rising clock edge.
// Backpressure: start acceptance is decided by the model (idle or done cycle only).
module tb_output_part;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] srt [4];

  logic [3:0] pa [2];
  logic [3:0] pb [2];
  logic       pc [2];
  logic       bz [2];
  logic       dn [2];

  int checks   = 0;
  int failures = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  output_part #(.STROBE_CYCLES(2), .HOLD_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .srt_num0(srt[0]), .srt_num1(srt[1]), .srt_num2(srt[2]), .srt_num3(srt[3]),
    .partA(pa[0]), .partB(pb[0]), .partC(pc[0]), .busy(bz[0]), .done(dn[0])
  );

  output_part #(.STROBE_CYCLES(1), .HOLD_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .srt_num0(srt[0]), .srt_num1(srt[1]), .srt_num2(srt[2]), .srt_num3(srt[3]),
    .partA(pa[1]), .partB(pb[1]), .partC(pc[1]), .busy(bz[1]), .done(dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int scyc(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int hcyc(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic int wlen(int i);
    return 1 + scyc(i) + hcyc(i);
  endfunction

  // Reference model: remaining frame cycles, position in frame, frame words.
  int         rem  [2];
  int         pos  [2];
  logic       dexp [2];
  logic [3:0] mw   [2][4];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        rem[i]  = 0;
        pos[i]  = 0;
        dexp[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        dexp[i] = 1'b0;
        if (rem[i] == 0 && start) begin
          rem[i] = 4 * wlen(i);
          pos[i] = 0;
          for (int k = 0; k < 4; k++) begin
            mw[i][k] = srt[k];
            if (i == 0) q0.push_back({4'b0001 << k, srt[k]});
            else        q1.push_back({4'b0001 << k, srt[k]});
          end
        end else if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
          pos[i] = pos[i] + 1;
          if (rem[i] == 0) dexp[i] = 1'b1;
        end
      end
    end
  end

  // Expected {partA, partB, partC, busy, done} for the current cycle.
  function automatic logic [10:0] exp_out(int i);
    int k;
    int ph;
    logic strobe;
    if (rem[i] == 0) return {4'd0, 4'd0, 1'b0, 1'b0, dexp[i]};
    k      = pos[i] / wlen(i);
    ph     = pos[i] % wlen(i);
    strobe = (ph >= 1) && (ph <= scyc(i));
    return {4'b0001 << k, mw[i][k], strobe, 1'b1, 1'b0};
  endfunction

  // Monitor: per-cycle output check, receiver model on partC rise, frame-end check.
  logic       prevc [2] = '{1'b0, 1'b0};
  logic [3:0] rx    [2][4];
  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) rx[i][k] = 4'd0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [10:0] act;
      logic [10:0] exv;
      logic [7:0]  ent;
      logic        ok;
      act = {pa[i], pb[i], pc[i], bz[i], dn[i]};
      exv = exp_out(i);
      checks++;
      if (act !== exv) begin
        failures++;
        $display("FAIL outputs inst%0d t=%0t got A/B/C/busy/done=%h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                 i, $time, act[10:7], act[6:3], act[2], act[1], act[0],
                 exv[10:7], exv[6:3], exv[2], exv[1], exv[0]);
      end
      if (!rst_n) begin
        if (i == 0) q0.delete(); else q1.delete();
        prevc[i] = 1'b0;
      end else begin
        if (pc[i] && !prevc[i]) begin
          checks++;
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            failures++;
            $display("FAIL rx_unexpected inst%0d t=%0t got strobe with A/B=%h/%h want no strobe",
                     i, $time, pa[i], pb[i]);
          end else begin
            ent = (i == 0) ? q0.pop_front() : q1.pop_front();
            if ({pa[i], pb[i]} !== ent) begin
              failures++;
              $display("FAIL rx_load inst%0d t=%0t got A/B=%h/%h want %h/%h",
                       i, $time, pa[i], pb[i], ent[7:4], ent[3:0]);
            end
            for (int k = 0; k < 4; k++)
              if (pa[i][k]) rx[i][k] = pb[i];
          end
        end
        prevc[i] = pc[i];
        if (dexp[i]) begin
          ok = 1'b1;
          for (int k = 0; k < 4; k++) ok = ok && (rx[i][k] === mw[i][k]);
          checks++;
          if (!ok) begin
            failures++;
            $display("FAIL rx_frame inst%0d t=%0t got %h,%h,%h,%h want %h,%h,%h,%h", i, $time,
                     rx[i][0], rx[i][1], rx[i][2], rx[i][3], mw[i][0], mw[i][1], mw[i][2], mw[i][3]);
          end
        end
      end
    end
    if (end_req && !end_ack) begin
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
        failures++;
        $display("FAIL drain got pending words %0d/%0d want 0/0", q0.size(), q1.size());
      end
      end_ack = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_words(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    srt[0] = a; srt[1] = b; srt[2] = c; srt[3] = d;
  endtask

  task automatic rand_words();
    for (int k = 0; k < 4; k++) srt[k] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_words(4'd0, 4'd0, 4'd0, 4'd0);
    step(3);

    // Start in the same cycle reset is released; basic 1,3,7,9 frame.
    rst_n = 1'b1;
    start = 1'b1;
    set_words(4'd1, 4'd3, 4'd7, 4'd9);
    step(1);
    start = 1'b0;
    step(20);

    // Restart and word changes mid-frame must not disturb the frame.
    rand_words();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    start = 1'b1;
    set_words(4'hF, 4'hF, 4'hF, 4'hF);
    step(1);
    start = 1'b0;
    step(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(20);

    // Start held high: back-to-back frames with changing inputs.
    start = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rand_words();
      step(1);
    end
    start = 1'b0;
    step(20);

    // Reset during word 2 strobe of the default instance, then a fresh frame.
    rand_words();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(9);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    rand_words();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(20);

    // Random traffic with occasional resets.
    for (int n = 0; n < 60; n++) begin
      start = ($urandom_range(0, 3) == 0);
      rand_words();
      rst_n = ($urandom_range(0, 24) != 0);
      step($urandom_range(1, 6));
      rst_n = 1'b1;
    end
    start = 1'b0;
    step(40);

    end_req = 1'b1;
    step(3);
    if (!end_ack) begin
      failures++;
      $display("FAIL end_handshake got no ack want ack");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_part.md
OUTPUT_PART -- requirements
Module: output_part

Interface
REQ-001 Parameter STROBE_CYCLES, default 2, number of cycles partC is held high per word; legal range 1..15.
REQ-002 Parameter HOLD_CYCLES, default 1, number of cycles partA/partB are held after partC falls; legal range 0..15.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 Port start  input  1  request to transmit one frame of four words; sampled on the rising edge of clk.
REQ-006 Port srt_num0..srt_num3  input  4 each  sorted words; srt_num0 is sent first.
REQ-007 Port partA  output  4  one-hot word select; 0001, 0010, 0100, 1000 select words 0 to 3 in that order.
REQ-008 Port partB  output  4  data of the selected word.
REQ-009 Port partC  output  1  load strobe; the receiver captures partB on the rising edge of partC.
REQ-010 Port busy  output  1  high while a frame is in progress.
REQ-011 Port done  output  1  one-cycle pulse at the end of a frame.
REQ-012 All outputs SHALL be registered.

Function
REQ-013 States SHALL be IDLE, SETUP, STROBE and HOLD.
REQ-014 In IDLE with start=1, the block SHALL capture srt_num0..3 into internal registers, clear the word index to 0 and enter SETUP.
REQ-015 SETUP SHALL last 1 cycle, with partA=onehot(index), partB=captured[index] and partC=0; the block then enters STROBE.
REQ-016 STROBE SHALL last STROBE_CYCLES cycles with partC=1 and partA/partB unchanged.
REQ-017 HOLD SHALL last HOLD_CYCLES cycles with partC=0 and partA/partB unchanged; when HOLD_CYCLES=0, HOLD is skipped.
REQ-018 After HOLD, the block SHALL enter SETUP with index+1 if index<3; if index=3 it SHALL return to IDLE.
REQ-019 Each word SHALL take 1+STROBE_CYCLES+HOLD_CYCLES cycles; with default parameters a frame is 16 cycles.
REQ-020 partA and partB SHALL change only on SETUP entry, so that partB is stable for at least 1 cycle before the rising edge of partC and for HOLD_CYCLES cycles after its falling edge.
REQ-021 busy SHALL be 1 in SETUP, STROBE and HOLD, and 0 in IDLE.
REQ-022 done SHALL be 1 for exactly the first IDLE cycle after a completed frame; it SHALL NOT pulse after an aborted frame.
REQ-023 In IDLE, partA and partB SHALL be 0000 and partC SHALL be 0.
REQ-024 start while busy=1 SHALL be ignored; it is not queued.
REQ-025 start in the cycle where done=1 SHALL be accepted, giving back-to-back frames with no extra gap.
REQ-026 Changes on srt_num* after capture SHALL NOT affect the frame in progress.
REQ-027 The index SHALL be 2 bits and SHALL never wrap during a frame; only the path index=3 to IDLE ends a frame.

Reset
REQ-028 When rst_n=0, the block SHALL immediately set state=IDLE, partA=0000, partB=0000, partC=0, busy=0, done=0, the index to 0, the cycle counter to 0 and the captured words to 0.
REQ-029 Reset during a frame SHALL abort it; after reset is released, the block SHALL wait in IDLE for a new start and SHALL NOT resume the aborted frame.
REQ-030 The first start SHALL be honoured on the first rising edge of clk after rst_n goes high.

Verification
REQ-031 Defaults, srt_num0..3=1,3,7,9, start pulse -> partA 0001/0010/0100/1000 with partB 1/3/7/9; each partC high 2 cycles; busy high 16 cycles; done pulse on cycle 17.
REQ-032 Scoreboard: a receiver model loads on the rising edge of partC -> after done, its registers hold 1,3,7,9; partB is stable throughout every partC-high window.
REQ-033 HOLD_CYCLES=0, STROBE_CYCLES=1 -> each word takes 2 cycles; frame is 8 cycles; partC has 4 separate 1-cycle pulses, each preceded by a low SETUP cycle.
REQ-034 start pulsed again mid-frame and srt_num changed to F,F,F,F mid-frame -> the frame still delivers the original values; no second frame starts.
REQ-035 start held high through done -> a second frame begins in the done cycle; no idle gap occurs between the two frames.
REQ-036 rst_n pulsed low during word 2 STROBE -> all outputs 0 in the same cycle; no done pulse; a new start sends all four words from word 0.
